// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_div_pkg;

  localparam int DIV_W   = 16;
  localparam int DIV_LAT = DIV_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_div16_if.sv
// Operand/result handshake bundle for seq_div16. Signal names are seen from
// the divider: i_* flow into it, o_* flow out of it.
interface seq_div16_if #(parameter int W = seq_div_pkg::DIV_W);

  logic                i_valid;
  logic                o_ready;
  logic signed [W-1:0] i_a;
  logic signed [W-1:0] i_b;
  logic                o_valid;
  logic                i_ready;
  logic signed [W-1:0] o_q;
  logic signed [W-1:0] o_r;
  logic                o_div0;
  logic                o_ovf;

  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_q, o_r, o_div0, o_ovf
  );

  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_q, o_r, o_div0, o_ovf
  );

endinterface

// File: rtl/udiv_step.sv
// One radix-2 restoring iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, subtract the divisor if it fits
// and shift the resulting quotient bit into the low end of quo.
module udiv_step #(
  parameter int W = 16
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] quo,
  input  logic [W:0]   divisor,
  output logic [W:0]   rem_next,
  output logic [W-1:0] quo_next
);

  logic [W+1:0] shifted;

  // Trial subtraction; keep the shifted remainder when the divisor does not fit
  always_comb begin
    shifted = {rem, quo[W-1]};
    if (shifted >= {1'b0, divisor}) begin
      rem_next = (W+1)'(shifted - {1'b0, divisor});
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = (W+1)'(shifted);
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_div16.sv
// Sequential signed divider: restoring division on magnitudes, one quotient
// bit per cycle, then sign correction and div-by-zero / overflow overrides.
// Fixed latency of W+2 cycles from acceptance to o_valid for every operand.
module seq_div16
  import seq_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic        i_clk,
  input  logic        i_rst,
  seq_div16_if.slave  bus
);

  localparam int                  CNT_W   = $clog2(W);
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] NEG_ONE = '1;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic                accept;

  logic [W:0]          mag_b;
  logic [W:0]          rem;
  logic [W-1:0]        quo;
  logic [W:0]          rem_step;
  logic [W-1:0]        quo_step;
  logic signed [W-1:0] a_lat;
  logic                sign_q;
  logic                sign_r;
  logic                div0_lat;
  logic                ovf_lat;

  // |v| widened by one bit so the most negative value has a magnitude
  function automatic logic [W:0] magnitude(input logic signed [W-1:0] v);
    logic signed [W:0] ext;
    ext = {v[W-1], v};
    return ext[W] ? $unsigned(-ext) : $unsigned(ext);
  endfunction

  // Two's-complement negate of an unsigned magnitude when neg is set
  function automatic logic signed [W-1:0] apply_sign(input logic [W-1:0] mag,
                                                     input logic         neg);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  assign accept = bus.i_valid && bus.o_ready;

  udiv_step #(.W(W)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (mag_b),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: IDLE -> CALC (W cycles) -> FIX -> DONE -> IDLE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept)            state_next = CALC;
      CALC: if (cnt == '0)         state_next = FIX;
      FIX:                         state_next = DONE;
      DONE: if (bus.i_ready)       state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // Handshake outputs depend on state only
  always_comb begin
    bus.o_ready = (state == IDLE);
    bus.o_valid = (state == DONE);
  end

  // Iteration counter: W-1 down to 0 across the CALC cycles
  always_ff @(posedge i_clk) begin
    if (i_rst)               cnt <= '0;
    else if (accept)         cnt <= CNT_W'(W - 1);
    else if (state == CALC)  cnt <= cnt - 1'b1;
  end

  // Operand capture at acceptance, then one restoring step per CALC cycle
  always_ff @(posedge i_clk) begin
    if (accept) begin
      quo      <= W'(magnitude(bus.i_a));
      mag_b    <= magnitude(bus.i_b);
      rem      <= '0;
      a_lat    <= bus.i_a;
      sign_q   <= bus.i_a[W-1] ^ bus.i_b[W-1];
      sign_r   <= bus.i_a[W-1];
      div0_lat <= (bus.i_b == '0);
      ovf_lat  <= (bus.i_a == MIN_VAL) && (bus.i_b == NEG_ONE);
    end else if (state == CALC) begin
      rem <= rem_step;
      quo <= quo_step;
    end
  end

  // Result registers: signed results and special-case overrides loaded in FIX
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_q    <= '0;
      bus.o_r    <= '0;
      bus.o_div0 <= 1'b0;
      bus.o_ovf  <= 1'b0;
    end else if (state == FIX) begin
      if (div0_lat) begin
        bus.o_q <= NEG_ONE;
        bus.o_r <= a_lat;
      end else if (ovf_lat) begin
        bus.o_q <= MIN_VAL;
        bus.o_r <= '0;
      end else begin
        bus.o_q <= apply_sign(quo, sign_q);
        bus.o_r <= apply_sign(rem[W-1:0], sign_r);
      end
      bus.o_div0 <= div0_lat;
      bus.o_ovf  <= ovf_lat;
    end
  end

endmodule

// File: doc/seq_div16.md
Name: seq_div16

Overview:
- Sequential signed integer divider, W-bit dividend by W-bit divisor. Produces quotient and remainder.
- Acts as the inverse-arithmetic companion to the 16-bit multiplier datapath. Used to verify or undo multiply results in the test bench and in fixed-point rescaling.
- Radix-2 restoring algorithm on magnitudes, one quotient bit per cycle, followed by sign correction.
- Valid/ready handshake on both input and output.

Parameters:
- W, 16, operand/result width in bits. Fixed latency is W+2.

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  operands valid
- o_ready  out  1  divider can accept operands
- i_a  in  W  signed dividend
- i_b  in  W  signed divisor
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_q  out  W  signed quotient, truncated toward zero
- o_r  out  W  signed remainder; sign follows dividend; |r| < |b|
- o_div0  out  1  divisor was zero
- o_ovf  out  1  i_a = -2^(W-1) and i_b = -1

Behaviour:
- Reset (sync, i_rst=1): state IDLE; o_ready=1; o_valid=0; o_q, o_r, o_div0, o_ovf = 0.
- Reset mid-operation aborts the division with no output. The divider is back in IDLE the cycle after i_rst deasserts.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready at edge t, latch |a| and |b| as (W+1)-bit unsigned values so that -2^(W-1) is representable.
  - Also latch sign_q = a[W-1]^b[W-1], sign_r = a[W-1], the div0 flag and the ovf flag.
  - Clear the partial remainder; iteration counter = W-1; go to CALC.
- CALC: one iteration per cycle for W cycles.
  - rem = {rem, quo[MSB]}; quo shifts left.
  - If rem >= |b|: rem -= |b| and shift in 1; else shift in 0.
  - Counter reaches 0 -> FIX.
- FIX: apply signs and register the outputs.
  - q = sign_q ? -quo : quo.
  - r = sign_r ? -rem : rem.
  - div0 override: q = all ones (-1), r = i_a.
  - ovf override: q = -2^(W-1), r = 0.
  - Then go to DONE.
- DONE:
  - o_valid=1 with o_q/o_r/flags held stable until i_ready=1.
  - On o_valid & i_ready, go to IDLE; o_valid=0 next cycle.
- Latency: if accepted at edge t, o_valid is first high in the cycle after edge t+W+1 (i.e. W+2 cycles). This is uniform for all operands, including div0 and ovf.
- o_ready=0 in CALC, FIX and DONE. No same-cycle accept while DONE drains. Back-to-back throughput is one result per W+3 cycles minimum.
- i_a and i_b are don't-care except at the acceptance edge.
- i_valid held while o_ready=0 is ignored; the upstream must hold operands until accepted.
- Outputs are registered; there is no combinational path from inputs to outputs except none (o_ready derives from state only).

Decomposition:
- Package seq_div_pkg:
  - state enum (IDLE, CALC, FIX, DONE)
  - DIV_W = 16
  - DIV_LAT = DIV_W + 2
- One natural sub-module: udiv_step. Combinational single restoring iteration:
  - inputs: rem, quo, divisor
  - outputs: next rem, next quo
- Top holds the FSM, counter, magnitude/sign logic and output registers.

Test Plan:
- 100 / 7 -> o_q=14, o_r=2, flags 0; o_valid first high exactly 18 cycles after the handshake.
- -100 / 7 -> q=-14, r=-2. 100 / -7 -> q=-14, r=2. -100 / -7 -> q=14, r=-2.
- 1234 / 0 -> q=16'hFFFF, r=1234, o_div0=1. -32768 / -1 -> q=-32768 (16'h8000), r=0, o_ovf=1. Both at latency 18.
- -32768 / 3 -> q=-10922, r=-2. 32767 / 32767 -> q=1, r=0. 5 / 9 -> q=0, r=5.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid -> outputs stable, o_ready=0 throughout. Release -> o_valid drops and o_ready rises the next cycle; a new op is accepted then.
- Assert i_rst at CALC iteration 8 for 1 cycle -> next cycle o_valid=0, o_ready=1, outputs 0. A subsequent 50/5 returns q=10, r=0. Plus a 10k random-operand run against a reference model (truncating division, RISC-V-style div0/ovf).
